// File: rtl/prog_loader.sv
// Streams a byte image into data memory, then releases the CPU and times its run.
// Define LOADER_CHECKSUM_EN to add the csum output (running mod-256 sum of loaded bytes).
module prog_loader #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 9,
   parameter int CYC_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [7:0]        dm_di,
   output logic              cpu_reset,
   input  logic              cpu_done,
   output logic              busy,
   output logic              run_done,
   output logic              err_len,
`ifdef LOADER_CHECKSUM_EN
   output logic [7:0]        csum,
`endif
   output logic [CYC_W-1:0]  run_cycles
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      FLUSH = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] base_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  count_r;
   logic              seen_low_r;
   logic              beat_s;
   logic              start_bad_s;
   logic [LEN_W-1:0]  count_inc_s;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_r;

   assign csum = csum_r;
`endif

   assign s_ready     = (state_r == LOAD);
   assign beat_s      = s_valid && s_ready;
   assign start_bad_s = (length > MAX_LEN);
   assign count_inc_s = count_r + LEN_W'(1);

   // Control FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         cpu_reset  <= 1'b1;
         dm_we      <= 1'b0;
         dm_addr    <= '0;
         dm_di      <= 8'h00;
         busy       <= 1'b0;
         run_done   <= 1'b0;
         err_len    <= 1'b0;
         run_cycles <= '0;
         base_r     <= '0;
         len_r      <= '0;
         count_r    <= '0;
         seen_low_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_r     <= 8'h00;
`endif
      end else begin
         dm_we <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  if (start_bad_s) begin
                     err_len <= 1'b1;
                  end else begin
                     err_len    <= 1'b0;
                     run_done   <= 1'b0;
                     busy       <= 1'b1;
                     run_cycles <= '0;
                     count_r    <= '0;
                     base_r     <= base_addr;
                     len_r      <= length;
`ifdef LOADER_CHECKSUM_EN
                     csum_r     <= 8'h00;
`endif
                     state_r    <= (length == '0) ? FLUSH : LOAD;
                  end
               end
            end
            LOAD: begin
               // Write lands one cycle after its beat; addr/data hold between beats.
               if (beat_s) begin
                  dm_we   <= 1'b1;
                  dm_addr <= base_r + count_r[ADDR_W-1:0];
                  dm_di   <= s_data;
                  count_r <= count_inc_s;
`ifdef LOADER_CHECKSUM_EN
                  csum_r  <= csum_r + s_data;
`endif
                  if (count_inc_s == len_r) begin
                     state_r <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               state_r    <= RUN;
               cpu_reset  <= 1'b0;
               seen_low_r <= 1'b0;
            end
            RUN: begin
               if (run_cycles != '1) begin
                  run_cycles <= run_cycles + CYC_W'(1);
               end
               // Only a rising done after a low sample counts as completion.
               if (!cpu_done) begin
                  seen_low_r <= 1'b1;
               end else if (seen_low_r) begin
                  state_r   <= DONE;
                  cpu_reset <= 1'b1;
                  busy      <= 1'b0;
                  run_done  <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               cpu_reset <= 1'b1;
               busy      <= 1'b0;
               run_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the CPU top: streams a data image into data memory over a valid/ready byte stream, then releases the CPU and times its run.
- Holds the CPU in reset while loading.
- Drives the dmem write port (we/addr/di) while loading.
- Releases CPU reset, counts cycles until the CPU's done rises, then re-holds reset and reports completion.

Parameters:
ADDR_W, 8, dmem address width; image addresses wrap modulo 2^ADDR_W
LEN_W, 9, width of length input (must hold 2^ADDR_W)
CYC_W, 16, width of run-cycle counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin load of a new image
base_addr  input  ADDR_W  first dmem address written
length  input  LEN_W  number of bytes to load, 0..2^ADDR_W
s_valid  input  1  stream byte valid
s_data  input  8  stream byte
s_ready  output  1  loader accepts byte this cycle
dm_we  output  1  dmem write enable
dm_addr  output  ADDR_W  dmem write address
dm_di  output  8  dmem write data
cpu_reset  output  1  reset to CPU top; high = CPU held
cpu_done  input  1  CPU done flag
busy  output  1  high in LOAD, FLUSH, RUN
run_done  output  1  high in DONE until next accepted start
err_len  output  1  sticky: start seen with length > 2^ADDR_W; cleared by next accepted start
run_cycles  output  CYC_W  cycles CPU spent out of reset

Behaviour:
Clock and reset:
- One clock, clk; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, cpu_reset=1, s_ready=0, dm_we=0, dm_addr=0, dm_di=0.
  - busy=0, run_done=0, err_len=0, run_cycles=0.
  - Byte counter=0.
- Reset mid-operation aborts immediately to these values. A partially loaded image is not rolled back.

States:
- IDLE: cpu_reset=1.
  - On start with length > 2^ADDR_W: set err_len; stay IDLE.
  - On start with length==0: go to FLUSH.
  - Otherwise latch base_addr and length, clear counter and run_cycles, and go to LOAD.
- LOAD: s_ready=1 combinationally in this state only.
  - A beat transfers when s_valid&&s_ready.
  - On each beat, next cycle: dm_we=1, dm_addr=(base+count) mod 2^ADDR_W, dm_di=s_data; count increments. Write latency is one cycle.
  - No beat: dm_we=0 next cycle; dm_addr and dm_di hold.
  - When the beat making count==length transfers, go to FLUSH. s_ready drops in the same cycle the registered state changes, so no extra beat is accepted.
- FLUSH: one cycle; the last registered write lands. cpu_reset stays 1; then go to RUN.
- RUN: cpu_reset=0.
  - run_cycles increments every RUN cycle and saturates at all-ones.
  - Done detection is edge-based: cpu_done must be sampled low at least once in RUN, then a high sample goes to DONE. A done level already asserted at release is not taken as completion.
- DONE: cpu_reset=1, run_done=1, run_cycles frozen. On start, same handling as IDLE.

Rules:
- start outside IDLE or DONE is ignored (no error flag).
- busy = state in {LOAD, FLUSH, RUN}.
- dm_we is 0 outside the cycle after a LOAD beat.
- Wrap-around: base=0xF0, length=0x20 writes 0xF0..0xFF then 0x00..0x0F.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - Extra output csum[7:0], reset 0, cleared on accepted start.
  - Updated each accepted beat: csum = csum + s_data (mod 256).
  - Stable from FLUSH onward.
- Macro undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic load: base=0x10, length=4, bytes 0xA1,0xB2,0xC3,0xD4 back-to-back -> dm_we pulses 4 cycles, addr 0x10..0x13 with matching data; FLUSH one cycle; cpu_reset falls the cycle after FLUSH.
- Backpressure/gaps: s_valid toggled 1,0,0,1,1,0,1 with length=4 -> exactly 4 writes, each one cycle after its beat, dm_we=0 in gap cycles.
- Wrap and full length: base=0xFE, length=256 -> writes 0xFE,0xFF,0x00..0xFD; then length=257 -> err_len=1, state stays IDLE, cpu_reset=1.
- Run timing: after release, cpu_done held high 2 cycles, low 10 cycles, then high -> DONE; run_cycles=13; run_done=1; cpu_reset=1.
- Edge cases: length=0 -> IDLE, FLUSH, RUN with no dm_we. start during LOAD is ignored. Reset asserted mid-LOAD (after 2 of 4 beats) -> next cycle IDLE, dm_we=0, busy=0, cpu_reset=1.
- LOADER_CHECKSUM_EN: bytes 0xFF,0x02,0x10 -> csum=0x11.
